// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned CNT_W = 5;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

    // RISC-V funct3 encodings for the M extension
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // rs1 is interpreted as signed
    function automatic logic op_signed1(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is interpreted as signed
    function automatic logic op_signed2(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_operand_cond.sv
// Sign detection and conditional negation of two operands.
// fin=0: sign comes from the op's signedness and the operand MSB (operand prep).
// fin=1: sign is forced by fin_neg_a/b (result sign correction).
module muldiv_operand_cond
    import muldiv_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic [2:0]   md_op,
    input  logic         fin,
    input  logic         fin_neg_a,
    input  logic         fin_neg_b,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         neg_a,
    output logic         neg_b,
    output logic [W-1:0] mag_a,
    output logic [W-1:0] mag_b
);

    // Pick the negate condition, then two's-complement where required
    always_comb begin
        neg_a = fin ? fin_neg_a : (op_signed1(md_op) & a[W-1]);
        neg_b = fin ? fin_neg_b : (op_signed2(md_op) & b[W-1]);
        mag_a = neg_a ? (~a + W'(1)) : a;
        mag_b = neg_b ? (~b + W'(1)) : b;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN: multiply leaves the MUL state as
// soon as the remaining multiplier bits are all zero.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       md_op,
    input  logic [XLEN-1:0]  data1,
    input  logic [XLEN-1:0]  data2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    state_e               state, state_d;
    logic [2*XLEN-1:0]    acc, acc_d;       // MUL: product; DIV: {remainder, quotient}
    logic [2*XLEN-1:0]    opb, opb_d;       // MUL: shifted multiplicand; DIV: divisor in low word
    logic [XLEN-1:0]      mplier, mplier_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 neg_q, neg_q_d;   // product / quotient sign
    logic                 neg_r, neg_r_d;   // remainder sign
    logic [XLEN-1:0]      result_d;
    logic                 resp_valid_d;
    logic [TAG_W-1:0]     resp_tag_d;

    logic                 in_neg1, in_neg2;
    logic [XLEN-1:0]      in_mag1, in_mag2;
    logic [XLEN-1:0]      div_sel;
    logic                 fin_sa, fin_sb;
    logic [2*XLEN-1:0]    fin_prod, fin_div;
    logic [XLEN+1:0]      div_diff;
    logic [XLEN-1:0]      spec_val;
    logic                 unused_fin;

    // Operand magnitudes and signs from the live request
    muldiv_operand_cond #(.W(XLEN)) u_in_cond (
        .md_op     (md_op),
        .fin       (1'b0),
        .fin_neg_a (1'b0),
        .fin_neg_b (1'b0),
        .a         (data1),
        .b         (data2),
        .neg_a     (in_neg1),
        .neg_b     (in_neg2),
        .mag_a     (in_mag1),
        .mag_b     (in_mag2)
    );

    assign div_sel = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];

    // Sign correction of the 64-bit product and of the selected quotient/remainder
    muldiv_operand_cond #(.W(2*XLEN)) u_fin_cond (
        .md_op     (op_q),
        .fin       (1'b1),
        .fin_neg_a (neg_q),
        .fin_neg_b (op_q[1] ? neg_r : neg_q),
        .a         (acc),
        .b         ({{XLEN{1'b0}}, div_sel}),
        .neg_a     (fin_sa),
        .neg_b     (fin_sb),
        .mag_a     (fin_prod),
        .mag_b     (fin_div)
    );

    assign unused_fin = ^{fin_sa, fin_sb, fin_div[2*XLEN-1:XLEN]};

    assign req_ready = (state == S_IDLE) && !flush;
    assign busy      = (state != S_IDLE);

    // Trial subtraction for one restoring-divide step
    assign div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, opb[XLEN-1:0]};

    // Value returned by the division special cases
    always_comb begin
        spec_val = '0;
        if (data2 == '0) begin
            spec_val = md_op[1] ? data1 : DIV0_QUOT;
        end else begin
            spec_val = md_op[1] ? '0 : INT_MIN;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state;
        acc_d        = acc;
        opb_d        = opb;
        mplier_d     = mplier;
        cnt_d        = cnt;
        op_d         = op_q;
        tag_d        = tag_q;
        neg_q_d      = neg_q;
        neg_r_d      = neg_r;
        result_d     = result;
        resp_valid_d = resp_valid;
        resp_tag_d   = resp_tag;

        if (flush) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_d    = md_op;
                        tag_d   = req_tag;
                        cnt_d   = '0;
                        neg_q_d = in_neg1 ^ in_neg2;
                        neg_r_d = in_neg1;
                        if (!md_op[2]) begin
                            acc_d    = '0;
                            opb_d    = {{XLEN{1'b0}}, in_mag1};
                            mplier_d = in_mag2;
                            state_d  = S_MUL;
                        end else if ((data2 == '0) ||
                                     (!md_op[0] && (data1 == INT_MIN) && (data2 == '1))) begin
                            acc_d   = {spec_val, spec_val};
                            neg_q_d = 1'b0;
                            neg_r_d = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, in_mag1};
                            opb_d   = {{XLEN{1'b0}}, in_mag2};
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (mplier[0]) begin
                        acc_d = acc + opb;
                    end
                    opb_d    = opb << 1;
                    mplier_d = mplier >> 1;
                    cnt_d    = cnt + CNT_W'(1);
`ifdef MULDIV_EARLY_OUT_EN
                    if ((cnt == CNT_W'(XLEN - 1)) || (mplier[XLEN-1:1] == '0)) begin
                        state_d = S_DONE;
                    end
`else
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state_d = S_DONE;
                    end
`endif
                end
                S_DIV: begin
                    if (!div_diff[XLEN+1]) begin
                        acc_d = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {acc[2*XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!resp_valid) begin
                        if (op_q[2]) begin
                            result_d = fin_div[XLEN-1:0];
                        end else if (op_q == MD_MUL) begin
                            result_d = fin_prod[XLEN-1:0];
                        end else begin
                            result_d = fin_prod[2*XLEN-1:XLEN];
                        end
                        resp_valid_d = 1'b1;
                        resp_tag_d   = tag_q;
                    end else if (resp_ready) begin
                        resp_valid_d = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            acc        <= '0;
            opb        <= '0;
            mplier     <= '0;
            cnt        <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            result     <= '0;
            resp_valid <= 1'b0;
            resp_tag   <= '0;
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            opb        <= opb_d;
            mplier     <= mplier_d;
            cnt        <= cnt_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            neg_q      <= neg_q_d;
            neg_r      <= neg_r_d;
            result     <= result_d;
            resp_valid <= resp_valid_d;
            resp_tag   <= resp_tag_d;
        end
    end

endmodule
